lfo_rate_control: RTL and testbench
===================================

Name: lfo_rate_control

Overview:
Multi-channel successor to the single-channel LFO rate block. It converts per-channel frequency numbers into per-channel angle-increment enables for the sawtooth/CORDIC LFO chain. One shared ROM is time-multiplexed across channels. Probability changes glide smoothly instead of stepping. The random bitstream is replaced by a deterministic first-order delta-sigma accumulator, and the divisor is selectable at run time.

Parameters:
CHANNELS, 2, number of independent LFO channels (1..8)
RESOLUTION, 16, probability full scale = 2**RESOLUTION
ADDR_WIDTH, 8, width of one frequency number / ROM address
FREQ_TABLE_FILE, "", ROM init file, (RESOLUTION+1)-bit words
GLIDE_SHIFT, 4, glide step = difference >> GLIDE_SHIFT; 0 = immediate
DIV_WIDTH, 3, width of divisor_sel_i

Ports:
clk_i  in  1  system clock
srst_i  in  1  synchronous active-high reset
sample_tick_i  in  1  one-clock sample strobe
frequency_number_i  in  CHANNELS*ADDR_WIDTH  channel k in bits [k*ADDR_WIDTH +: ADDR_WIDTH]
divisor_sel_i  in  DIV_WIDTH  generate on every 2**sel accepted ticks
angle_incr_en_o  out  CHANNELS  per-channel increment enable, one-clock pulse
update_o  out  1  one-clock strobe, angle_incr_en_o valid
busy_o  out  1  sweep in progress
overrun_o  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: all outputs 0, FSM IDLE, tick counter 0, every cur_prob and acc 0.
- Reset mid-sweep aborts the sweep. No update_o for that tick.
- FSM states: IDLE, ADDR, CALC, DONE.
  - IDLE: sample_tick_i accepted.
    - Latch frequency_number_i into a shadow register.
    - Latch gen_en = ((tick_cnt & (2**divisor_sel_i - 1)) == 0).
    - tick_cnt++ (DIV_WIDTH' widths: tick_cnt is 2**DIV_WIDTH-1 bits wide, wraps).
    - ch = 0, go to ADDR.
  - ADDR: drive ROM address = shadow[ch]. ROM has 1-clock latency. Go to CALC.
  - CALC, channel ch:
    - tgt = min(rom_data, 2**RESOLUTION).
    - Glide: d = tgt - cur (signed, RESOLUTION+2 bits). step = d >>> GLIDE_SHIFT. If step == 0 and d != 0, step = sign(d)*1. cur_new = cur + step.
    - If gen_en: s = acc + cur_new. If s >= 2**RESOLUTION, bit = 1 and acc = s - 2**RESOLUTION; else bit = 0 and acc = s.
    - If not gen_en: bit = 0, acc unchanged. Glide still applies.
    - If ch == CHANNELS-1 go to DONE; else ch++ and go to ADDR.
  - DONE:
    - angle_incr_en_o <= collected bits (all 0 when !gen_en).
    - update_o <= 1 for exactly one clock.
    - Go to IDLE.
- Latency: tick to update_o = 2*CHANNELS+1 clocks. busy_o is high from the clock after acceptance through DONE.
- angle_incr_en_o is held only during the update_o clock and is 0 otherwise.
- A sample_tick_i while busy_o is high is dropped, sets overrun_o (cleared only by srst_i), and does not advance tick_cnt.
- Boundaries:
  - cur = 2**RESOLUTION gives bit = 1 on every generating tick.
  - cur = 0 gives bit = 0.
  - Widths: acc is RESOLUTION bits; cur is RESOLUTION+1 bits.
- Frequency-number changes between ticks affect only the next accepted tick.

Decomposition:
- Package lfo_rate_pkg: FSM state enum (IDLE/ADDR/CALC/DONE) and the glide step helper function.
- Reuse the existing rom module (DWIDTH = RESOLUTION+1, AWIDTH = ADDR_WIDTH).
- One natural sub-module, lfo_glide_dsm: combinational glide + delta-sigma slice taking cur, acc, tgt, gen_en and returning cur_new, acc_new, bit. The top level holds the FSM and the per-channel register arrays.

Test Plan:
- GLIDE_SHIFT=0, ROM[5]=65536, ch0=5, sel=0, 4 ticks -> en[0]=1 on every update_o; update_o 5 clocks after each tick (CHANNELS=2).
- GLIDE_SHIFT=0, ROM[3]=32768, ch1=3, sel=0 -> en[1] sequence 0,1,0,1; ch0 (ROM[0]=0) always 0.
- ROM=65536, GLIDE_SHIFT=0, sel=2, 9 ticks -> en=1 only on ticks 0,4,8; update_o still pulses on all 9 ticks.
- GLIDE_SHIFT=4, target 65536 from cur 0 -> cur 4096, 7936, 11536 over the first three ticks; en[0] bit pattern matches the model.
- Second tick 2 clocks after the first (busy) -> dropped; overrun_o=1 sticky; one update_o only; tick_cnt advances by 1.
- srst_i asserted in CALC -> no update_o; outputs and overrun_o 0; next tick starts from cur=0, acc=0.

Source files
------------

// File: rtl/lfo_rate_pkg.sv
// Purpose: shared types and helpers for the multi-channel LFO rate block.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: the sweep FSM state enum and the glide step function used by
// lfo_glide_dsm. GLIDE_W is wide enough for RESOLUTION up to 32.
package lfo_rate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } lfo_state_t;

    localparam int GLIDE_W = 34;

    // One glide step toward the target. The shifted step is forced to +/-1
    // when it would otherwise truncate to zero, so cur always reaches tgt.
    function automatic logic signed [GLIDE_W-1:0] glide_step(
        input logic signed [GLIDE_W-1:0] diff,
        input int unsigned               shift
    );
        logic signed [GLIDE_W-1:0] step;
        step = diff >>> shift;
        if (step == '0 && diff != '0) begin
            step = diff[GLIDE_W-1] ? '1 : GLIDE_W'(1);
        end
        return step;
    endfunction

endpackage

// File: rtl/lfo_glide_dsm.sv
// Purpose: one channel's glide toward target probability plus first-order delta-sigma.
// Latency: combinational.
// Backpressure: none.
//
// Ports: cur/acc current glide value and accumulator, tgt raw ROM word,
// gen_en generate this tick; cur_new/acc_new next state, en_bit output bit.
// cur never overshoots tgt, so cur_new stays within 0..2**RESOLUTION and
// acc + cur_new always fits RESOLUTION+1 bits.
module lfo_glide_dsm
    import lfo_rate_pkg::*;
#(
    parameter int RESOLUTION  = 16,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic [RESOLUTION:0]   cur,
    input  logic [RESOLUTION-1:0] acc,
    input  logic [RESOLUTION:0]   tgt,
    input  logic                  gen_en,
    output logic [RESOLUTION:0]   cur_new,
    output logic [RESOLUTION-1:0] acc_new,
    output logic                  en_bit
);

    localparam logic [RESOLUTION:0] FULL = {1'b1, {RESOLUTION{1'b0}}};

    logic [RESOLUTION:0]       tgt_sat;
    logic signed [GLIDE_W-1:0] diff;
    logic signed [GLIDE_W-1:0] step;
    logic signed [GLIDE_W-1:0] cur_ext;
    logic [RESOLUTION:0]       dsm_sum;
    logic                      unused_cur_hi;

    always_comb begin
        tgt_sat = (tgt > FULL) ? FULL : tgt;
        diff    = $signed(GLIDE_W'(tgt_sat)) - $signed(GLIDE_W'(cur));
        step    = glide_step(diff, GLIDE_SHIFT);
        cur_ext = $signed(GLIDE_W'(cur)) + step;
        cur_new = cur_ext[RESOLUTION:0];
        // Carry out of the accumulator is the output bit; subtracting full
        // scale is simply dropping that carry.
        dsm_sum = {1'b0, acc} + cur_new;
        en_bit  = gen_en & dsm_sum[RESOLUTION];
        acc_new = gen_en ? dsm_sum[RESOLUTION-1:0] : acc;
    end

    assign unused_cur_hi = ^cur_ext[GLIDE_W-1:RESOLUTION+1];

endmodule

// File: rtl/rom.sv
// Purpose: frequency-number to probability lookup ROM.
// Latency: 1 clock from addr to rd_dat.
// Backpressure: none; a new address is accepted every clock.
//
// Ports: clk_i clock, addr read address, rd_dat registered read word.
// This behavioural model serves a built-in ramp table,
// word = (addr - 1) << (DWIDTH - 3) for addr > 0 and 0 for addr 0,
// saturating at the word width. The named INIT_FILE is consumed by the
// ROM macro generation flow, not by this model.
module rom #(
    parameter int    DWIDTH    = 17,
    parameter int    AWIDTH    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] rd_dat
);

    localparam longint unsigned WORD_MAX = (64'd1 << DWIDTH) - 64'd1;

    function automatic longint unsigned ramp_word(
        input longint unsigned a,
        input int unsigned     shift
    );
        if (a == 64'd0) begin
            return 64'd0;
        end
        return (a - 64'd1) << shift;
    endfunction

    longint unsigned   word;
    logic [DWIDTH-1:0] table_dat;
    logic              unused_init_file;

    assign unused_init_file = (INIT_FILE != "");

    always_comb begin
        word      = ramp_word(64'(addr), DWIDTH - 3);
        table_dat = (word > WORD_MAX) ? '1 : word[DWIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        rd_dat <= table_dat;
    end

endmodule

// File: rtl/lfo_rate_control.sv
// Purpose: per-channel LFO angle-increment enables from frequency numbers, shared ROM.
// Latency: sample_tick_i to update_o is 2*CHANNELS+1 clocks.
// Backpressure: none; ticks arriving while busy_o is high are dropped and flag overrun_o.
//
// Ports: clk_i, srst_i (sync, active high), sample_tick_i strobe,
// frequency_number_i (channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]),
// divisor_sel_i (generate every 2**sel accepted ticks); angle_incr_en_o
// per-channel pulse valid with update_o, busy_o sweep active, overrun_o sticky.
module lfo_rate_control
    import lfo_rate_pkg::*;
#(
    parameter int    CHANNELS        = 2,
    parameter int    RESOLUTION      = 16,
    parameter int    ADDR_WIDTH      = 8,
    parameter string FREQ_TABLE_FILE = "",
    parameter int    GLIDE_SHIFT     = 4,
    parameter int    DIV_WIDTH       = 3
) (
    input  logic                           clk_i,
    input  logic                           srst_i,
    input  logic                           sample_tick_i,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] frequency_number_i,
    input  logic [DIV_WIDTH-1:0]           divisor_sel_i,
    output logic [CHANNELS-1:0]            angle_incr_en_o,
    output logic                           update_o,
    output logic                           busy_o,
    output logic                           overrun_o
);

    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TICK_W = (2 ** DIV_WIDTH) - 1;

    lfo_state_t state_q;
    lfo_state_t state_d;

    logic [ADDR_WIDTH-1:0] shadow_q [CHANNELS];
    logic [TICK_W-1:0]     tick_cnt_q;
    logic [TICK_W-1:0]     div_mask;
    logic                  gen_en_q;
    logic [CH_W-1:0]       ch_q;
    logic                  last_ch;
    logic                  tick_accept;

    logic [RESOLUTION:0]   cur_q [CHANNELS];
    logic [RESOLUTION-1:0] acc_q [CHANNELS];
    logic [CHANNELS-1:0]   bits_q;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [RESOLUTION:0]   rom_dat;
    logic [RESOLUTION:0]   cur_new;
    logic [RESOLUTION-1:0] acc_new;
    logic                  en_bit;

    assign tick_accept = (state_q == ST_IDLE) && sample_tick_i;
    assign last_ch     = (ch_q == CH_W'(CHANNELS - 1));
    assign div_mask    = TICK_W'((32'd1 << divisor_sel_i) - 32'd1);

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (sample_tick_i) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_CALC;
            ST_CALC: state_d = last_ch ? ST_DONE : ST_ADDR;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. The ROM registers its address every clock; the word for
    // channel ch addressed during ADDR is on rom_dat during the following CALC.
    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        rom_addr = shadow_q[ch_q];
    end

    // Sweep datapath and per-channel state
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            tick_cnt_q <= '0;
            gen_en_q   <= 1'b0;
            ch_q       <= '0;
            bits_q     <= '0;
            overrun_o  <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                shadow_q[k] <= '0;
                cur_q[k]    <= '0;
                acc_q[k]    <= '0;
            end
        end else begin
            if (sample_tick_i && state_q != ST_IDLE) begin
                overrun_o <= 1'b1;
            end
            if (tick_accept) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    shadow_q[k] <= frequency_number_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                end
                gen_en_q   <= ((tick_cnt_q & div_mask) == '0);
                tick_cnt_q <= tick_cnt_q + 1'b1;
                ch_q       <= '0;
                bits_q     <= '0;
            end
            if (state_q == ST_CALC) begin
                cur_q[ch_q]  <= cur_new;
                acc_q[ch_q]  <= acc_new;
                bits_q[ch_q] <= en_bit;
                if (!last_ch) begin
                    ch_q <= ch_q + 1'b1;
                end
            end
        end
    end

    // Enables are presented only for the single update_o clock.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            update_o        <= 1'b0;
            angle_incr_en_o <= '0;
        end else begin
            update_o        <= (state_q == ST_DONE);
            angle_incr_en_o <= (state_q == ST_DONE) ? bits_q : '0;
        end
    end

    rom #(
        .DWIDTH    (RESOLUTION + 1),
        .AWIDTH    (ADDR_WIDTH),
        .INIT_FILE (FREQ_TABLE_FILE)
    ) u_rom (
        .clk_i  (clk_i),
        .addr   (rom_addr),
        .rd_dat (rom_dat)
    );

    lfo_glide_dsm #(
        .RESOLUTION  (RESOLUTION),
        .GLIDE_SHIFT (GLIDE_SHIFT)
    ) u_glide_dsm (
        .cur     (cur_q[ch_q]),
        .acc     (acc_q[ch_q]),
        .tgt     (rom_dat),
        .gen_en  (gen_en_q),
        .cur_new (cur_new),
        .acc_new (acc_new),
        .en_bit  (en_bit)
    );

endmodule

// File: tb/tb_lfo_rate_control.sv
// Purpose: directed self-checking bench for lfo_rate_control.
// Latency: n/a.
// Backpressure: n/a.
//
// Two instances share all inputs: dut0 with immediate glide, dut4 with
// GLIDE_SHIFT=4. Built-in ROM words used: [0]=0, [3]=32768, [5]=65536,
// [6]=81920 (clamped to full scale by the datapath).
module tb_lfo_rate_control;

    logic        clk;
    logic        srst;
    logic        tick;
    logic [15:0] freq;
    logic [2:0]  sel;

    logic [1:0]  en0, en4;
    logic        upd0, upd4, busy0, busy4, ovr0, ovr4;

    int checks = 0;
    int errors = 0;

    lfo_rate_control #(
        .CHANNELS (2), .RESOLUTION (16), .ADDR_WIDTH (8),
        .FREQ_TABLE_FILE (""), .GLIDE_SHIFT (0), .DIV_WIDTH (3)
    ) dut0 (
        .clk_i (clk), .srst_i (srst), .sample_tick_i (tick),
        .frequency_number_i (freq), .divisor_sel_i (sel),
        .angle_incr_en_o (en0), .update_o (upd0), .busy_o (busy0), .overrun_o (ovr0)
    );

    lfo_rate_control #(
        .CHANNELS (2), .RESOLUTION (16), .ADDR_WIDTH (8),
        .FREQ_TABLE_FILE (""), .GLIDE_SHIFT (4), .DIV_WIDTH (3)
    ) dut4 (
        .clk_i (clk), .srst_i (srst), .sample_tick_i (tick),
        .frequency_number_i (freq), .divisor_sel_i (sel),
        .angle_incr_en_o (en4), .update_o (upd4), .busy_o (busy4), .overrun_o (ovr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        srst = 1'b1;
        tick = 1'b0;
        repeat (2) @(negedge clk);
        srst = 1'b0;
    endtask

    // One accepted tick; returns clocks to update_o (20 = never seen),
    // enables at the update clock and the values one clock later.
    task automatic pulse_tick(output int lat, output logic [1:0] e0, output logic [1:0] e4,
                              output logic u4, output logic post_u, output logic [1:0] post_e);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        lat = 0;
        while (upd0 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e0 = en0;
        e4 = en4;
        u4 = upd4;
        @(negedge clk);
        post_u = upd0;
        post_e = en0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        tick = 1'b0;
        freq = '0;
        sel  = '0;
        repeat (3) @(negedge clk);
        if ({en0, upd0, busy0, ovr0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_dut0: got %b expected 00000", {en0, upd0, busy0, ovr0});
        end
        checks++;
        if ({en4, upd4, busy4, ovr4} !== 5'b0) begin
            errors++;
            $display("FAIL reset_dut4: got %b expected 00000", {en4, upd4, busy4, ovr4});
        end
        checks++;
        if (dut4.cur_q[0] !== 17'd0) begin
            errors++;
            $display("FAIL reset_cur: got %0d expected 0", dut4.cur_q[0]);
        end
        checks++;
        srst = 1'b0;
    endtask

    // ch0 at full scale, ch1 above full scale (clamped): every tick fires both.
    task automatic test_full_scale();
        int lat;
        logic [1:0] e0, e4, pe;
        logic u4, pu;
        apply_reset();
        freq = {8'd6, 8'd5};
        sel  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pulse_tick(lat, e0, e4, u4, pu, pe);
            if (lat !== 5) begin
                errors++;
                $display("FAIL full_latency[%0d]: got %0d expected 5", i, lat);
            end
            checks++;
            if (e0 !== 2'b11) begin
                errors++;
                $display("FAIL full_en[%0d]: got %b expected 11", i, e0);
            end
            checks++;
            if (u4 !== 1'b1) begin
                errors++;
                $display("FAIL full_upd_dut4[%0d]: got %b expected 1", i, u4);
            end
            checks++;
            if ({pu, pe} !== 3'b000) begin
                errors++;
                $display("FAIL full_pulse_width[%0d]: got %b expected 000", i, {pu, pe});
            end
            checks++;
        end
    endtask

    task automatic test_half_rate();
        int lat;
        logic [1:0] e0, e4, pe;
        logic u4, pu;
        logic [1:0] exp_en [4] = '{2'b00, 2'b10, 2'b00, 2'b10};
        apply_reset();
        freq = {8'd3, 8'd0};
        sel  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pulse_tick(lat, e0, e4, u4, pu, pe);
            if (e0 !== exp_en[i]) begin
                errors++;
                $display("FAIL half_en[%0d]: got %b expected %b", i, e0, exp_en[i]);
            end
            checks++;
        end
    endtask

    task automatic test_divisor();
        int lat;
        logic [1:0] e0, e4, pe, exp_e;
        logic u4, pu;
        apply_reset();
        freq = {8'd5, 8'd5};
        sel  = 3'd2;
        for (int i = 0; i < 9; i++) begin
            pulse_tick(lat, e0, e4, u4, pu, pe);
            exp_e = (i % 4 == 0) ? 2'b11 : 2'b00;
            if (lat !== 5) begin
                errors++;
                $display("FAIL div_latency[%0d]: got %0d expected 5", i, lat);
            end
            checks++;
            if (e0 !== exp_e) begin
                errors++;
                $display("FAIL div_en[%0d]: got %b expected %b", i, e0, exp_e);
            end
            checks++;
        end
    endtask

    // Target 65536 from 0 with shift 4: cur 4096, 7936, 11536, 14911, 18075,
    // 21041; accumulator first carries on the sixth tick (77595).
    task automatic test_glide();
        int lat;
        logic [1:0] e0, e4, pe;
        logic u4, pu;
        logic [16:0] exp_cur [3] = '{17'd4096, 17'd7936, 17'd11536};
        logic [1:0]  exp_e4 [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        apply_reset();
        freq = {8'd0, 8'd5};
        sel  = 3'd0;
        for (int i = 0; i < 6; i++) begin
            pulse_tick(lat, e0, e4, u4, pu, pe);
            if (i < 3) begin
                if (dut4.cur_q[0] !== exp_cur[i]) begin
                    errors++;
                    $display("FAIL glide_cur[%0d]: got %0d expected %0d", i, dut4.cur_q[0], exp_cur[i]);
                end
                checks++;
            end
            if (e4 !== exp_e4[i]) begin
                errors++;
                $display("FAIL glide_en[%0d]: got %b expected %b", i, e4, exp_e4[i]);
            end
            checks++;
        end
    endtask

    task automatic test_overrun();
        int lat, n_upd;
        logic [1:0] e0, e4, pe, cap;
        logic u4, pu;
        apply_reset();
        freq = {8'd0, 8'd5};
        sel  = 3'd1;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_busy: got %b expected 1", busy0);
        end
        checks++;
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        if (ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_flag: got %b expected 1", ovr0);
        end
        checks++;
        n_upd = 0;
        cap   = 2'bxx;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (upd0 === 1'b1) begin
                n_upd++;
                cap = en0;
            end
        end
        if (n_upd !== 1) begin
            errors++;
            $display("FAIL ovr_update_count: got %0d expected 1", n_upd);
        end
        checks++;
        if (cap !== 2'b01) begin
            errors++;
            $display("FAIL ovr_first_en: got %b expected 01", cap);
        end
        checks++;
        // Dropped tick must not count: next tick is count 1 (no generate), then 2.
        pulse_tick(lat, e0, e4, u4, pu, pe);
        if (e0 !== 2'b00) begin
            errors++;
            $display("FAIL ovr_cnt1_en: got %b expected 00", e0);
        end
        checks++;
        pulse_tick(lat, e0, e4, u4, pu, pe);
        if (e0 !== 2'b01) begin
            errors++;
            $display("FAIL ovr_cnt2_en: got %b expected 01", e0);
        end
        checks++;
        if (ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b expected 1", ovr0);
        end
        checks++;
    endtask

    task automatic test_reset_mid_sweep();
        int lat, n_upd;
        logic [1:0] e0, e4, pe;
        logic u4, pu;
        apply_reset();
        freq = {8'd0, 8'd3};
        sel  = 3'd0;
        // First sweep with a dropped tick: acc0 ends at 32768, overrun set.
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (8) @(negedge clk);
        // Second sweep, reset while channel 0 is in CALC.
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        @(negedge clk);
        if (ovr0 !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_ovr: got %b expected 1", ovr0);
        end
        checks++;
        srst = 1'b1;
        @(negedge clk); srst = 1'b0;
        n_upd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (upd0 === 1'b1) n_upd++;
        end
        if (n_upd !== 0) begin
            errors++;
            $display("FAIL rst_no_update: got %0d expected 0", n_upd);
        end
        checks++;
        if ({en0, busy0, ovr0} !== 4'b0) begin
            errors++;
            $display("FAIL rst_outputs: got %b expected 0000", {en0, busy0, ovr0});
        end
        checks++;
        if (dut4.cur_q[0] !== 17'd0) begin
            errors++;
            $display("FAIL rst_cur_cleared: got %0d expected 0", dut4.cur_q[0]);
        end
        checks++;
        // Fresh start: acc 0 + 32768 gives no carry; glide restarts at 2048.
        pulse_tick(lat, e0, e4, u4, pu, pe);
        if (e0 !== 2'b00) begin
            errors++;
            $display("FAIL rst_after_en1: got %b expected 00", e0);
        end
        checks++;
        if (dut4.cur_q[0] !== 17'd2048) begin
            errors++;
            $display("FAIL rst_after_cur: got %0d expected 2048", dut4.cur_q[0]);
        end
        checks++;
        pulse_tick(lat, e0, e4, u4, pu, pe);
        if (e0 !== 2'b01) begin
            errors++;
            $display("FAIL rst_after_en2: got %b expected 01", e0);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_half_rate();
        test_divisor();
        test_glide();
        test_overrun();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
